switch_gate_sequencer: RTL

//  Upstream stimulus stage for the charge-storage switch.

---
 rtl/switch_gate_sequencer_if.sv | 27 ++
 rtl/switch_gate_sequencer.sv | 117 +++++++++++
 2 files changed

// File: rtl/switch_gate_sequencer_if.sv
// rtl/switch_gate_sequencer_if.sv - start/abort/config and gate/data/status bundle for the gate sequencer
interface switch_gate_sequencer_if #(
  parameter int CNT_W = 16,
  parameter int REP_W = 8
);
  logic             start;
  logic             abort;
  logic [CNT_W-1:0] on_len;
  logic [CNT_W-1:0] off_len;
  logic [REP_W-1:0] reps;
  logic             data_val;
  logic             gate_out;
  logic             data_out;
  logic             busy;
  logic             done;
  logic [REP_W-1:0] rep_left;

  modport master (
    output start, abort, on_len, off_len, reps, data_val,
    input  gate_out, data_out, busy, done, rep_left
  );

  modport slave (
    input  start, abort, on_len, off_len, reps, data_val,
    output gate_out, data_out, busy, done, rep_left
  );
endinterface

// File: rtl/switch_gate_sequencer.sv
// rtl/switch_gate_sequencer.sv - ON/OFF gate pulse schedule with start/busy/done handshake
module switch_gate_sequencer #(
  parameter int CNT_W = 16,
  parameter int REP_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  switch_gate_sequencer_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ON, OFF, FIN} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] on_q, on_d;
  logic [CNT_W-1:0] off_q, off_d;
  logic [REP_W-1:0] rep_q, rep_d;
  logic             gate_q, gate_d;
  logic             data_q, data_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [CNT_W-1:0] on_eff;

  assign on_eff = (bus.on_len == '0) ? CNT_W'(1) : bus.on_len;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      on_q    <= '0;
      off_q   <= '0;
      rep_q   <= '0;
      gate_q  <= 1'b0;
      data_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      on_q    <= on_d;
      off_q   <= off_d;
      rep_q   <= rep_d;
      gate_q  <= gate_d;
      data_q  <= data_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // cnt_q holds the cycles remaining in the current phase after this one
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    on_d    = on_q;
    off_d   = off_q;
    rep_d   = rep_q;
    gate_d  = gate_q;
    data_d  = data_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          on_d   = on_eff;
          off_d  = bus.off_len;
          data_d = bus.data_val;
          if (bus.reps == '0) begin
            state_d = FIN;
            done_d  = 1'b1;
          end else begin
            state_d = ON;
            gate_d  = 1'b1;
            busy_d  = 1'b1;
            rep_d   = bus.reps - REP_W'(1);
            cnt_d   = on_eff - CNT_W'(1);
          end
        end
      end
      ON, OFF: begin
        if (bus.abort) begin
          state_d = IDLE;
          gate_d  = 1'b0;
          busy_d  = 1'b0;
          rep_d   = '0;
          cnt_d   = '0;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else if (state_q == ON && off_q != '0) begin
          state_d = OFF;
          gate_d  = 1'b0;
          cnt_d   = off_q - CNT_W'(1);
        end else if (rep_q != '0) begin
          state_d = ON;
          gate_d  = 1'b1;
          rep_d   = rep_q - REP_W'(1);
          cnt_d   = on_q - CNT_W'(1);
        end else begin
          state_d = FIN;
          gate_d  = 1'b0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      FIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.gate_out = gate_q;
  assign bus.data_out = data_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.rep_left = rep_q;
endmodule
